// File: rtl/serial_fifo_port.sv
// serial_fifo_port
// Buffered serial endpoint that sits behind the data memory's serial port.
// Two independent circular FIFOs, each 2**DEPTH_LOG2 bytes deep:
//   TX : data memory -> host. Pushed by mem_wren_in, drained over a
//        valid/ready stream (tx_data_out / tx_valid_out / tx_ready_in).
//   RX : host -> data memory. Pushed over a valid/ready stream
//        (rx_data_in / rx_valid_in / rx_ready_out), popped by mem_rden_in.
// Ports:
//   clock, reset                     single clock, async active-high reset
//   mem_data_in, mem_wren_in         TX push side (from data memory)
//   mem_rden_in                      RX pop strobe (from data memory)
//   mem_data_out, mem_valid_out      RX head byte / RX not empty
//   mem_ready_out                    TX not full
//   tx_data_out, tx_valid_out        TX head byte / TX not empty
//   tx_ready_in                      host accepts TX byte
//   rx_data_in, rx_valid_in          host byte offer
//   rx_ready_out                     RX not full
//   tx_drop_out, rx_underrun_out     sticky error flags, cleared by reset only
module serial_fifo_port #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] mem_data_in,
  input  logic       mem_wren_in,
  input  logic       mem_rden_in,
  output logic [7:0] mem_data_out,
  output logic       mem_valid_out,
  output logic       mem_ready_out,
  output logic [7:0] tx_data_out,
  output logic       tx_valid_out,
  input  logic       tx_ready_in,
  input  logic [7:0] rx_data_in,
  input  logic       rx_valid_in,
  output logic       rx_ready_out,
  output logic       tx_drop_out,
  output logic       rx_underrun_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  // Storage (intentionally not reset)
  logic [7:0] tx_mem_r [DEPTH];
  logic [7:0] rx_mem_r [DEPTH];

  logic [DEPTH_LOG2-1:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
  logic [DEPTH_LOG2:0]   tx_count_r, rx_count_r;
  logic                  tx_drop_r, rx_underrun_r;

  // Status comes only from registered counts, so no input reaches ready/valid.
  logic tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

  assign tx_empty_s = (tx_count_r == CNT_ZERO);
  assign tx_full_s  = (tx_count_r == CNT_FULL);
  assign rx_empty_s = (rx_count_r == CNT_ZERO);
  assign rx_full_s  = (rx_count_r == CNT_FULL);

  // Acceptance is judged on the start-of-cycle count, so a pop never makes
  // room for a same-cycle push into a full FIFO and vice versa.
  assign tx_push_s = mem_wren_in && !tx_full_s;
  assign tx_pop_s  = tx_ready_in && !tx_empty_s;
  assign rx_push_s = rx_valid_in && !rx_full_s;
  assign rx_pop_s  = mem_rden_in && !rx_empty_s;

  // TX pointers, count and drop flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wptr_r  <= '0;
      tx_rptr_r  <= '0;
      tx_count_r <= '0;
      tx_drop_r  <= 1'b0;
    end else begin
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + PTR_ONE;
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PTR_ONE;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
        2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
        default: tx_count_r <= tx_count_r;
      endcase
      if (mem_wren_in && tx_full_s) tx_drop_r <= 1'b1;
    end
  end

  // RX pointers, count and underrun flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wptr_r     <= '0;
      rx_rptr_r     <= '0;
      rx_count_r    <= '0;
      rx_underrun_r <= 1'b0;
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PTR_ONE;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
        2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
        default: rx_count_r <= rx_count_r;
      endcase
      if (mem_rden_in && rx_empty_s) rx_underrun_r <= 1'b1;
    end
  end

  // Byte storage writes; a write during reset is harmless because the
  // pointers and counts are being cleared.
  always_ff @(posedge clock) begin
    if (tx_push_s) tx_mem_r[tx_wptr_r] <= mem_data_in;
    if (rx_push_s) rx_mem_r[rx_wptr_r] <= rx_data_in;
  end

  // Show-ahead head bytes, forced to zero when the FIFO is empty
  always_comb begin
    tx_data_out  = 8'h00;
    mem_data_out = 8'h00;
    if (tx_empty_s) tx_data_out = 8'h00;
    else            tx_data_out = tx_mem_r[tx_rptr_r];
    if (rx_empty_s) mem_data_out = 8'h00;
    else            mem_data_out = rx_mem_r[rx_rptr_r];
  end

  assign tx_valid_out    = !tx_empty_s;
  assign mem_ready_out   = !tx_full_s;
  assign mem_valid_out   = !rx_empty_s;
  assign rx_ready_out    = !rx_full_s;
  assign tx_drop_out     = tx_drop_r;
  assign rx_underrun_out = rx_underrun_r;

endmodule

// File: tb/tb_serial_fifo_port.sv
module tb_serial_fifo_port;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] mem_data_in = 8'h00;
  logic       mem_wren_in = 1'b0;
  logic       mem_rden_in = 1'b0;
  logic [7:0] mem_data_out;
  logic       mem_valid_out;
  logic       mem_ready_out;
  logic [7:0] tx_data_out;
  logic       tx_valid_out;
  logic       tx_ready_in = 1'b0;
  logic [7:0] rx_data_in = 8'h00;
  logic       rx_valid_in = 1'b0;
  logic       rx_ready_out;
  logic       tx_drop_out;
  logic       rx_underrun_out;

  int total = 0;
  int passed = 0;

  serial_fifo_port #(.DEPTH_LOG2(4)) dut (
    .clock(clock), .reset(reset),
    .mem_data_in(mem_data_in), .mem_wren_in(mem_wren_in), .mem_rden_in(mem_rden_in),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out), .mem_ready_out(mem_ready_out),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
    .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in), .rx_ready_out(rx_ready_out),
    .tx_drop_out(tx_drop_out), .rx_underrun_out(rx_underrun_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mem_wren_in = 1'b0; mem_rden_in = 1'b0; tx_ready_in = 1'b0;
    rx_valid_in = 1'b0; mem_data_in = 8'h00; rx_data_in = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (tx_valid_out !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", tx_valid_out); else passed++;
    total++; if (mem_valid_out !== 1'b0) $display("FAIL reset_mem_valid got %b exp 0", mem_valid_out); else passed++;
    total++; if (mem_ready_out !== 1'b1) $display("FAIL reset_mem_ready got %b exp 1", mem_ready_out); else passed++;
    total++; if (rx_ready_out !== 1'b1) $display("FAIL reset_rx_ready got %b exp 1", rx_ready_out); else passed++;
    total++; if (tx_data_out !== 8'h00 || mem_data_out !== 8'h00)
      $display("FAIL reset_data got %h/%h exp 00/00", tx_data_out, mem_data_out); else passed++;
    total++; if (tx_drop_out !== 1'b0 || rx_underrun_out !== 1'b0)
      $display("FAIL reset_flags got %b/%b exp 0/0", tx_drop_out, rx_underrun_out); else passed++;
  endtask

  task automatic test_tx_basic();
    tx_ready_in = 1'b1;
    mem_wren_in = 1'b1; mem_data_in = 8'h48;
    step();
    total++; if (tx_valid_out !== 1'b1 || tx_data_out !== 8'h48)
      $display("FAIL tx_basic_first got %b/%h exp 1/48", tx_valid_out, tx_data_out); else passed++;
    mem_data_in = 8'h69;
    step();
    mem_wren_in = 1'b0;
    total++; if (tx_valid_out !== 1'b1 || tx_data_out !== 8'h69)
      $display("FAIL tx_basic_second got %b/%h exp 1/69", tx_valid_out, tx_data_out); else passed++;
    step();
    total++; if (tx_valid_out !== 1'b0 || tx_data_out !== 8'h00)
      $display("FAIL tx_basic_empty got %b/%h exp 0/00", tx_valid_out, tx_data_out); else passed++;
    idle_inputs();
  endtask

  task automatic test_tx_full();
    tx_ready_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_wren_in = 1'b1; mem_data_in = 8'(i);
      step();
    end
    total++; if (mem_ready_out !== 1'b0 || tx_drop_out !== 1'b0)
      $display("FAIL tx_full_ready got %b/%b exp 0/0", mem_ready_out, tx_drop_out); else passed++;
    mem_data_in = 8'h10;
    step();
    mem_wren_in = 1'b0;
    total++; if (tx_drop_out !== 1'b1 || mem_ready_out !== 1'b0)
      $display("FAIL tx_full_drop got %b/%b exp 1/0", tx_drop_out, mem_ready_out); else passed++;
    tx_ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (tx_valid_out !== 1'b1 || tx_data_out !== 8'(i))
        $display("FAIL tx_full_drain[%0d] got %b/%h exp 1/%h", i, tx_valid_out, tx_data_out, 8'(i)); else passed++;
      step();
    end
    total++; if (tx_valid_out !== 1'b0 || mem_ready_out !== 1'b1)
      $display("FAIL tx_full_after got %b/%b exp 0/1", tx_valid_out, mem_ready_out); else passed++;
    idle_inputs();
  endtask

  task automatic test_rx_basic();
    rx_valid_in = 1'b1; rx_data_in = 8'hA5;
    step();
    rx_data_in = 8'h5A;
    step();
    rx_valid_in = 1'b0;
    total++; if (mem_valid_out !== 1'b1 || mem_data_out !== 8'hA5)
      $display("FAIL rx_head got %b/%h exp 1/a5", mem_valid_out, mem_data_out); else passed++;
    step();
    total++; if (mem_data_out !== 8'hA5)
      $display("FAIL rx_hold got %h exp a5", mem_data_out); else passed++;
    mem_rden_in = 1'b1;
    step();
    mem_rden_in = 1'b0;
    total++; if (mem_valid_out !== 1'b1 || mem_data_out !== 8'h5A)
      $display("FAIL rx_second got %b/%h exp 1/5a", mem_valid_out, mem_data_out); else passed++;
    mem_rden_in = 1'b1;
    step();
    mem_rden_in = 1'b0;
    total++; if (mem_valid_out !== 1'b0 || mem_data_out !== 8'h00 || rx_underrun_out !== 1'b0)
      $display("FAIL rx_empty got %b/%h/%b exp 0/00/0", mem_valid_out, mem_data_out, rx_underrun_out); else passed++;
    mem_rden_in = 1'b1;
    step();
    mem_rden_in = 1'b0;
    total++; if (rx_underrun_out !== 1'b1 || mem_valid_out !== 1'b0 || rx_ready_out !== 1'b1)
      $display("FAIL rx_underrun got %b/%b/%b exp 1/0/1", rx_underrun_out, mem_valid_out, rx_ready_out); else passed++;
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [7:0] bytes [40];
    int bad = 0;
    for (int i = 0; i < 40; i++) bytes[i] = 8'($urandom_range(0, 255));
    rx_valid_in = 1'b1; rx_data_in = bytes[0];
    step();
    for (int i = 1; i < 40; i++) begin
      rx_data_in = bytes[i]; mem_rden_in = 1'b1;
      if (mem_valid_out !== 1'b1 || rx_ready_out !== 1'b1 || mem_data_out !== bytes[i-1]) begin
        $display("FAIL wrap_byte[%0d] got %b/%h exp 1/%h", i - 1, mem_valid_out, mem_data_out, bytes[i-1]);
        bad++;
      end
      step();
    end
    total++; if (bad == 0) passed++;
    rx_valid_in = 1'b0;
    total++; if (mem_data_out !== bytes[39] || mem_valid_out !== 1'b1)
      $display("FAIL wrap_last got %b/%h exp 1/%h", mem_valid_out, mem_data_out, bytes[39]); else passed++;
    step();
    mem_rden_in = 1'b0;
    total++; if (mem_valid_out !== 1'b0)
      $display("FAIL wrap_empty got %b exp 0", mem_valid_out); else passed++;
    idle_inputs();
  endtask

  task automatic test_rx_full();
    logic [7:0] bytes [16];
    for (int i = 0; i < 16; i++) begin
      bytes[i] = 8'($urandom_range(0, 255));
      rx_valid_in = 1'b1; rx_data_in = bytes[i];
      step();
    end
    total++; if (rx_ready_out !== 1'b0 || mem_valid_out !== 1'b1)
      $display("FAIL rx_full_flags got %b/%b exp 0/1", rx_ready_out, mem_valid_out); else passed++;
    rx_data_in = 8'hEE; mem_rden_in = 1'b1;
    step();
    rx_valid_in = 1'b0; mem_rden_in = 1'b0;
    total++; if (rx_ready_out !== 1'b1)
      $display("FAIL rx_full_count15 got %b exp 1", rx_ready_out); else passed++;
    mem_rden_in = 1'b1;
    for (int i = 1; i < 16; i++) begin
      total++; if (mem_valid_out !== 1'b1 || mem_data_out !== bytes[i])
        $display("FAIL rx_full_drain[%0d] got %b/%h exp 1/%h", i, mem_valid_out, mem_data_out, bytes[i]); else passed++;
      step();
    end
    mem_rden_in = 1'b0;
    total++; if (mem_valid_out !== 1'b0)
      $display("FAIL rx_full_dropped got %b exp 0", mem_valid_out); else passed++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_wren_in = 1'b1; mem_data_in = 8'hC0 + 8'(i);
      step();
    end
    total++; if (tx_valid_out !== 1'b1 || tx_data_out !== 8'hC0)
      $display("FAIL mid_pre got %b/%h exp 1/c0", tx_valid_out, tx_data_out); else passed++;
    mem_data_in = 8'h77;
    #2 reset = 1'b1;
    #1;
    total++; if (tx_valid_out !== 1'b0 || mem_ready_out !== 1'b1 || tx_data_out !== 8'h00)
      $display("FAIL mid_async got %b/%b/%h exp 0/1/00", tx_valid_out, mem_ready_out, tx_data_out); else passed++;
    @(posedge clock);
    #2 reset = 1'b0;
    mem_wren_in = 1'b0;
    tx_ready_in = 1'b1;
    step();
    total++; if (tx_valid_out !== 1'b0 || tx_data_out !== 8'h00 || tx_drop_out !== 1'b0)
      $display("FAIL mid_after got %b/%h/%b exp 0/00/0", tx_valid_out, tx_data_out, tx_drop_out); else passed++;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic drop_m, under_m;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] exp_tx, exp_rx;
    int bad = 0;
    do_reset();
    drop_m = 1'b0; under_m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      mem_wren_in = ($urandom_range(0, 99) < 60);
      mem_data_in = 8'($urandom_range(0, 255));
      tx_ready_in = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 30 : 80));
      rx_valid_in = ($urandom_range(0, 99) < 60);
      rx_data_in  = 8'($urandom_range(0, 255));
      mem_rden_in = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 80 : 30));
      exp_tx = (txq.size() == 0) ? 8'h00 : txq[0];
      exp_rx = (rxq.size() == 0) ? 8'h00 : rxq[0];
      if (tx_valid_out !== (txq.size() != 0) || tx_data_out !== exp_tx ||
          mem_ready_out !== (txq.size() != 16) || mem_valid_out !== (rxq.size() != 0) ||
          mem_data_out !== exp_rx || rx_ready_out !== (rxq.size() != 16) ||
          tx_drop_out !== drop_m || rx_underrun_out !== under_m) begin
        if (bad < 5)
          $display("FAIL random_cycle[%0d] got tx %b/%h rdy %b rx %b/%h rdy %b fl %b%b exp tx %0d/%h rx %0d/%h fl %b%b",
                   c, tx_valid_out, tx_data_out, mem_ready_out, mem_valid_out, mem_data_out,
                   rx_ready_out, tx_drop_out, rx_underrun_out, txq.size(), exp_tx,
                   rxq.size(), exp_rx, drop_m, under_m);
        bad++;
      end
      tx_push = mem_wren_in && (txq.size() < 16);
      tx_pop  = tx_ready_in && (txq.size() > 0);
      rx_push = rx_valid_in && (rxq.size() < 16);
      rx_pop  = mem_rden_in && (rxq.size() > 0);
      if (mem_wren_in && txq.size() == 16) drop_m = 1'b1;
      if (mem_rden_in && rxq.size() == 0) under_m = 1'b1;
      if (tx_pop) void'(txq.pop_front());
      if (tx_push) txq.push_back(mem_data_in);
      if (rx_pop) void'(rxq.pop_front());
      if (rx_push) rxq.push_back(rx_data_in);
      step();
    end
    total++; if (bad == 0) passed++;
    else $display("FAIL random_summary got %0d bad cycles exp 0", bad);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_reset();
    test_rx_basic();
    test_wrap();
    test_rx_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_fifo_port.md
# serial_fifo_port

Buffered serial endpoint on the far side of the data memory's serial port. Accepts bytes the processor writes through the data memory (`serial_out` / `serial_wren_out`) into a TX FIFO and drains them to the host/test bench over a valid/ready byte stream. In the other direction, it buffers host bytes in an RX FIFO and presents them to the data memory (`serial_in` / `serial_valid_in` / `serial_ready_in`), popping one byte per `serial_rden_out` pulse.

## Interface
- DEPTH_LOG2, 4, log2 of each FIFO depth; DEPTH = 2**DEPTH_LOG2 entries per FIFO.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_data_in  input  8  byte from the data memory; connects to `serial_out`.
- mem_wren_in  input  1  one-cycle push strobe; connects to `serial_wren_out`.
- mem_rden_in  input  1  one-cycle pop strobe; connects to `serial_rden_out`.
- mem_data_out  output  8  RX head byte; connects to `serial_in`.
- mem_valid_out  output  1  RX FIFO not empty; connects to `serial_valid_in`.
- mem_ready_out  output  1  TX FIFO not full; connects to `serial_ready_in`.
- tx_data_out  output  8  TX head byte to the host.
- tx_valid_out  output  1  TX FIFO not empty.
- tx_ready_in  input  1  host accepts the TX byte this cycle.
- rx_data_in  input  8  byte from the host.
- rx_valid_in  input  1  host offers `rx_data_in`.
- rx_ready_out  output  1  RX FIFO not full.
- tx_drop_out  output  1  sticky flag: a write arrived while the TX FIFO was full.
- rx_underrun_out  output  1  sticky flag: a pop arrived while the RX FIFO was empty.

## Operation
- Two independent circular FIFOs, TX and RX. Each has DEPTH entries, DEPTH_LOG2-bit read and write pointers that wrap modulo DEPTH, and a (DEPTH_LOG2+1)-bit count.
- Status signals:
  - empty = (count == 0); full = (count == DEPTH).
  - Status is decoded from registered counts only. No combinational path exists from any input to any ready or valid output.
- TX push: accepted when `mem_wren_in` && !tx_full. Writes `mem_data_in` at wptr, then increments wptr.
  - `mem_wren_in` while full: byte is discarded, no state changes, `tx_drop_out` set.
- TX pop: accepted when `tx_valid_out` && `tx_ready_in`. Increments rptr.
- RX push: accepted when `rx_valid_in` && `rx_ready_out`. Otherwise `rx_data_in` is ignored.
- RX pop: accepted when `mem_rden_in` && !rx_empty.
  - `mem_rden_in` while empty: ignored, `rx_underrun_out` set.
- Simultaneous push and pop on one FIFO:
  - Both accepted under the rules above; count is unchanged, both pointers advance.
  - Full and empty are evaluated from the start-of-cycle count. A push while full is dropped even if a pop occurs in the same cycle. A pop while empty is ignored even if a push occurs in the same cycle.
- Data outputs are show-ahead: each presents the entry at rptr. They are forced to 8'h00 whenever the FIFO is empty. Storage arrays are not reset.
- Sticky flags clear only on reset.
- Byte order is strict FIFO in both directions; no byte is duplicated or reordered.

## Timing
- Reset (asynchronous assert, effective immediately):
  - Pointers and counts = 0, flags = 0.
  - `tx_valid_out` = 0, `mem_valid_out` = 0.
  - `mem_ready_out` = 1, `rx_ready_out` = 1.
  - `tx_data_out` = 8'h00, `mem_data_out` = 8'h00.
- Reset asserted mid-transfer discards all buffered bytes. Any strobes in the reset cycle are ignored.
- Latency:
  - A byte pushed at edge N appears on the corresponding data/valid output after edge N (visible in cycle N+1). Cut-through latency is 1 cycle.
  - Ready and valid update one cycle after the push/pop edge that changes the count.
- Throughput: one push and one pop per FIFO per cycle, sustained.
- `mem_ready_out` falls in the cycle after the DEPTH-th unpopped push. The data memory must check it before writing; writes that ignore it are dropped.
- Flags assert the cycle after the offending strobe.

## Test plan
- Reset, then push 8'h48, 8'h69 via `mem_wren_in` on consecutive cycles with `tx_ready_in`=1 -> `tx_valid_out` high for 2 cycles starting 1 cycle after the first push; `tx_data_out` = 8'h48 then 8'h69; then `tx_valid_out`=0 and `tx_data_out`=8'h00.
- Hold `tx_ready_in`=0, push bytes 0..16 (DEPTH=16) -> `mem_ready_out`=0 after 16 pushes; the 17th byte is dropped and `tx_drop_out`=1. Release `tx_ready_in` -> exactly 8'h00..8'h0F are drained in order.
- Host sends 8'hA5, 8'h5A with `rx_valid_in`; one `mem_rden_in` pulse -> `mem_data_out`=8'hA5 until the pop, then 8'h5A; a second pop sets `mem_valid_out`=0. A third pop sets `rx_underrun_out`=1 and leaves the count at 0.
- Pointer wrap: 40 bytes streamed through RX with one push and one pop every cycle -> count stays at 1 and all 40 bytes are delivered in order.
- Fill the RX FIFO to 16, then assert `rx_valid_in` and `mem_rden_in` in the same cycle -> new byte dropped (`rx_ready_out`=0), one pop accepted, count = 15.
- Reset asserted mid-stream with 5 bytes in TX -> `tx_valid_out`=0 and `mem_ready_out`=1 immediately; no stale byte appears after reset is released.
